// File: rtl/mac_ofifo.sv
// mac_ofifo: output alignment buffer behind mac_array.
// One FIFO per column captures that column's psum on its write strobe;
// a row is released only when every column holds at least one entry.
//
// Parameters:
//   COL   - number of columns (matches mac_array total_K)
//   BW    - psum width per column
//   DEPTH - entries per column FIFO (power of two, >= 2)
//
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset (clears pointers only)
//   in       - column psums, column j at in[BW*j +: BW]
//   wr       - per-column write strobe
//   rd       - row pop request (acts as ready, may be held high)
//   out      - head entry of each column, column j at out[BW*j +: BW]
//   o_valid  - every column non-empty, out is a complete row
//   o_full   - at least one column full
//   o_empty  - every column empty
//   o_err    - sticky error (only when MAC_OFIFO_ERR_EN is defined):
//              dropped write or pop request with no valid row
//
// Optional feature macro: MAC_OFIFO_ERR_EN
module mac_ofifo #(
    parameter int unsigned COL   = 8,
    parameter int unsigned BW    = 22,
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BW*COL-1:0] in,
    input  logic [COL-1:0]    wr,
    input  logic              rd,
    output logic [BW*COL-1:0] out,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_empty
`ifdef MAC_OFIFO_ERR_EN
    ,
    output logic              o_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [BW-1:0] mem_q  [COL][DEPTH];
    logic [PW-1:0] wptr_q [COL];
    logic [PW-1:0] wptr_d [COL];
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] rptr_d;

    logic [COL-1:0] col_empty;
    logic [COL-1:0] col_full;
    logic [COL-1:0] wr_ok;
    logic           pop;

    // Per-column status decoded from registered pointers only.
    // All columns share one read pointer since pops are row-wide.
    always_comb begin
        col_empty = '0;
        col_full  = '0;
        for (int j = 0; j < int'(COL); j++) begin
            col_empty[j] = (wptr_q[j] == rptr_q);
            col_full[j]  = (wptr_q[j] == {~rptr_q[AW], rptr_q[AW-1:0]});
        end
    end

    assign o_valid = ~|col_empty;
    assign o_empty = &col_empty;
    assign o_full  = |col_full;

    assign pop = rd & o_valid;

    // A full column still accepts a write when the row pop frees its head slot.
    always_comb begin
        wr_ok  = '0;
        rptr_d = rptr_q + PW'(pop);
        for (int j = 0; j < int'(COL); j++) begin
            wr_ok[j]  = wr[j] & (~col_full[j] | pop);
            wptr_d[j] = wptr_q[j] + PW'(wr_ok[j]);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rptr_q <= '0;
            for (int j = 0; j < int'(COL); j++) begin
                wptr_q[j] <= '0;
            end
        end else begin
            rptr_q <= rptr_d;
            for (int j = 0; j < int'(COL); j++) begin
                wptr_q[j] <= wptr_d[j];
            end
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < int'(COL); j++) begin
            if (wr_ok[j]) begin
                mem_q[j][wptr_q[j][AW-1:0]] <= in[BW*j +: BW];
            end
        end
    end

    // First-word fall-through read of each column head.
    always_comb begin
        out = '0;
        for (int j = 0; j < int'(COL); j++) begin
            out[BW*j +: BW] = mem_q[j][rptr_q[AW-1:0]];
        end
    end

`ifdef MAC_OFIFO_ERR_EN
    logic err_q;
    logic err_d;

    // Sticky flag: dropped write on a full column, or pop with no valid row.
    always_comb begin
        err_d = err_q;
        if ((|(wr & col_full) && !pop) || (rd && !o_valid)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`endif

endmodule
